cv32e40s_zcmp_sequencer: RTL and testbench

- Produces instructions for the ID-stage decoder; it sits between the IF aligner/compressed-decoder path and the ID decoder.
- Expands one 16-bit Zcmp instruction (cm.push, cm.pop, cm.popret, cm.popretz, cm.mvsa01, cm.mva01s) into an ordered stream of uncompressed 32-bit RV32I words (sw/lw/addi/jalr).
- The downstream decoder handles each emitted word as a normal I-decoder instruction.
- Sequence flags travel with every word so ID/WB can keep the expansion atomic with respect to interrupts and debug.

---
 rtl/cv32e40s_zcmp_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cv32e40s_zcmp_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_zcmp_sequencer.sv
// Expands one Zcmp push/pop/move instruction into an ordered stream of RV32I words
// for the ID decoder, with first/last flags so the expansion stays atomic.
module cv32e40s_zcmp_sequencer #(
    parameter bit ZCMP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        is_zcmp_o,
    output logic [31:0] seq_instr_o,
    output logic        seq_valid_o,
    input  logic        seq_ready_i,
    output logic        seq_first_o,
    output logic        seq_last_o,
    output logic        seq_active_o,
    input  logic        kill_i
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t      r_state;
    logic [3:0]  r_step;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2);
        return {imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // s-register index to architectural x-register (s0/s1 are x8/x9, s2.. start at x18)
    function automatic logic [4:0] sreg_x(input logic [3:0] k);
        return (k < 4'd2) ? ({1'b0, k} + 5'd8) : ({1'b0, k} + 5'd16);
    endfunction

    logic [15:0] w_c;
    logic        w_hdr, w_push, w_pop, w_popretz, w_popret, w_pp, w_mvsa, w_mvas, w_zcmp;
    logic        w_illegal;
    logic [3:0]  w_rlist, w_nsreg, w_n, w_lastidx, w_j;
    logic [1:0]  w_spimm;
    logic [6:0]  w_base, w_adj;
    logic [4:0]  w_reg, w_mv_s, w_mv_a;
    logic [11:0] w_off4, w_soff, w_loff, w_adj12;
    logic [31:0] w_word;
    logic        w_fire, w_last, w_unused;

    assign w_c       = instr_i[15:0];
    assign w_unused  = ^instr_i[31:16];
    assign w_hdr     = (w_c[1:0] == 2'b10) && (w_c[15:13] == 3'b101);
    assign w_push    = w_hdr && (w_c[12:8] == 5'b11000);
    assign w_pop     = w_hdr && (w_c[12:8] == 5'b11010);
    assign w_popretz = w_hdr && (w_c[12:8] == 5'b11100);
    assign w_popret  = w_hdr && (w_c[12:8] == 5'b11110);
    assign w_pp      = w_push | w_pop | w_popretz | w_popret;
    assign w_mvsa    = w_hdr && (w_c[12:10] == 3'b011) && (w_c[6:5] == 2'b01);
    assign w_mvas    = w_hdr && (w_c[12:10] == 3'b011) && (w_c[6:5] == 2'b11);
    assign w_zcmp    = w_pp | w_mvsa | w_mvas;

    assign w_rlist   = w_c[7:4];
    assign w_spimm   = w_c[3:2];
    assign w_illegal = (w_pp && (w_rlist < 4'd4)) || (w_mvsa && (w_c[9:7] == w_c[4:2]));

    // rlist 15 carries s10 and s11 together, hence 12 rather than 11
    assign w_nsreg = (w_rlist == 4'd15) ? 4'd12 : (w_rlist - 4'd4);
    assign w_n     = w_nsreg + 4'd1;
    always_comb begin
        w_base = 7'd16;
        case (w_rlist[3:2])
            2'b10:   w_base = 7'd32;
            2'b11:   w_base = (w_rlist == 4'd15) ? 7'd64 : 7'd48;
            default: w_base = 7'd16;
        endcase
    end
    assign w_adj   = w_base + {1'b0, w_spimm, 4'b0000};
    assign w_adj12 = {5'd0, w_adj};

    always_comb begin
        w_lastidx = 4'd0;
        if (w_illegal)          w_lastidx = 4'd0;
        else if (w_push | w_pop) w_lastidx = w_n;
        else if (w_popret)      w_lastidx = w_n + 4'd1;
        else if (w_popretz)     w_lastidx = w_n + 4'd2;
        else if (w_mvsa | w_mvas) w_lastidx = 4'd1;
    end

    // Register order is highest s-register first, ra last
    assign w_reg  = (r_step == w_nsreg) ? 5'd1 : sreg_x(w_nsreg - 4'd1 - r_step);
    assign w_off4 = {6'd0, r_step, 2'b00} + 12'd4;
    assign w_soff = 12'd0 - w_off4;
    assign w_loff = w_adj12 - w_off4;
    assign w_j    = r_step - w_n;
    assign w_mv_s = sreg_x({1'b0, (r_step == 4'd0) ? w_c[9:7] : w_c[4:2]});
    assign w_mv_a = (r_step == 4'd0) ? 5'd10 : 5'd11;

    always_comb begin
        w_word = 32'd0;
        if (w_illegal) begin
            w_word = 32'd0;
        end else if (w_pp) begin
            if (r_step < w_n)
                w_word = w_push ? enc_sw(w_soff, w_reg)
                                : enc_i(w_loff, 5'd2, 3'b010, w_reg, 7'b0000011);
            else if (w_popretz && (w_j == 4'd0))
                w_word = 32'h00000513;
            else if (w_j == {3'b000, w_popretz})
                w_word = enc_i(w_push ? (12'd0 - w_adj12) : w_adj12, 5'd2, 3'b000, 5'd2, 7'b0010011);
            else
                w_word = 32'h00008067;
        end else if (w_mvsa) begin
            w_word = enc_i(12'd0, w_mv_a, 3'b000, w_mv_s, 7'b0010011);
        end else if (w_mvas) begin
            w_word = enc_i(12'd0, w_mv_s, 3'b000, w_mv_a, 7'b0010011);
        end
    end

    generate
        if (ZCMP_EN) begin : g_en
            assign is_zcmp_o     = w_zcmp;
            assign seq_valid_o   = instr_valid_i & w_zcmp & ~kill_i;
            assign seq_instr_o   = w_zcmp ? w_word : 32'd0;
            assign seq_first_o   = (r_step == 4'd0);
            assign w_last        = w_zcmp && (r_step == w_lastidx);
            assign seq_last_o    = w_last;
            assign w_fire        = seq_valid_o & seq_ready_i;
            assign instr_ready_o = w_zcmp ? (w_fire & w_last) : seq_ready_i;
            assign seq_active_o  = (r_state == S_ACTIVE);
        end else begin : g_dis
            assign is_zcmp_o     = 1'b0;
            assign seq_valid_o   = 1'b0;
            assign seq_instr_o   = 32'd0;
            assign seq_first_o   = 1'b1;
            assign w_last        = 1'b0;
            assign seq_last_o    = 1'b0;
            assign w_fire        = 1'b0;
            assign instr_ready_o = seq_ready_i;
            assign seq_active_o  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
        end else if (kill_i) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
        end else if (w_fire) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_step  <= 4'd0;
            end else begin
                r_state <= S_ACTIVE;
                r_step  <= r_step + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40s_zcmp_sequencer.sv
// Directed bench for the Zcmp sequencer: hand-encoded expansions, stall, kill and reset.
module tb_cv32e40s_zcmp_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        is_zcmp_o;
    logic [31:0] seq_instr_o;
    logic        seq_valid_o;
    logic        seq_ready_i;
    logic        seq_first_o;
    logic        seq_last_o;
    logic        seq_active_o;
    logic        kill_i;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_w [16];

    cv32e40s_zcmp_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .is_zcmp_o     (is_zcmp_o),
        .seq_instr_o   (seq_instr_o),
        .seq_valid_o   (seq_valid_o),
        .seq_ready_i   (seq_ready_i),
        .seq_first_o   (seq_first_o),
        .seq_last_o    (seq_last_o),
        .seq_active_o  (seq_active_o),
        .kill_i        (kill_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one parcel with seq_ready_i high and checks every emitted word against exp_w
    task automatic run_seq(input string tag, input logic [15:0] c, input int n);
        instr_i       = {16'h0000, c};
        instr_valid_i = 1'b1;
        seq_ready_i   = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_w%0d", tag, i), seq_instr_o, exp_w[i]);
            chk($sformatf("%s_valid%0d", tag, i), 32'(seq_valid_o), 32'd1);
            chk($sformatf("%s_first%0d", tag, i), 32'(seq_first_o), 32'(i == 0));
            chk($sformatf("%s_last%0d", tag, i), 32'(seq_last_o), 32'(i == n - 1));
            chk($sformatf("%s_rdy%0d", tag, i), 32'(instr_ready_o), 32'(i == n - 1));
            @(posedge clk); #1;
        end
        instr_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_i = 32'h0; instr_valid_i = 1'b0; seq_ready_i = 1'b1; kill_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", 32'(seq_active_o), 32'd0);
        chk("rst_first", 32'(seq_first_o), 32'd1);
        chk("rst_valid", 32'(seq_valid_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Non-Zcmp parcels pass untouched
        instr_i = 32'h00000013; instr_valid_i = 1'b1;
        @(negedge clk);
        chk("nz_is", 32'(is_zcmp_o), 32'd0);
        chk("nz_valid", 32'(seq_valid_o), 32'd0);
        instr_i = 32'h00004082;
        @(negedge clk);
        chk("nz2_is", 32'(is_zcmp_o), 32'd0);
        chk("nz2_rdy", 32'(instr_ready_o), 32'd1);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;

        // cm.push {ra,s0},-16
        exp_w[0] = 32'hFE812E23; exp_w[1] = 32'hFE112C23; exp_w[2] = 32'hFF010113;
        run_seq("push2", 16'hB852, 3);

        // cm.popret {ra},16
        exp_w[0] = 32'h00C12083; exp_w[1] = 32'h01010113; exp_w[2] = 32'h00008067;
        run_seq("popret", 16'hBE42, 3);

        // cm.pop {ra,s0-s1},32
        exp_w[0] = 32'h01C12483; exp_w[1] = 32'h01812403; exp_w[2] = 32'h01412083;
        exp_w[3] = 32'h02010113;
        run_seq("pop3", 16'hBA66, 4);

        // cm.mvsa01 s0,s2 and cm.mva01s s1,s7
        exp_w[0] = 32'h00050413; exp_w[1] = 32'h00058913;
        run_seq("mvsa", 16'hAC2A, 2);
        exp_w[0] = 32'h00048513; exp_w[1] = 32'h000B8593;
        run_seq("mvas", 16'hACFE, 2);

        // Illegal forms: rlist<4 and mvsa01 with equal registers
        exp_w[0] = 32'h00000000;
        run_seq("ill_rl", 16'hB822, 1);
        run_seq("ill_mv", 16'hAC22, 1);

        // cm.push {ra,s0-s11},-112: 14 words, spot-check the register-map boundary
        instr_i = 32'h0000B8FE; instr_valid_i = 1'b1; seq_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0)  chk("big_w0", seq_instr_o, 32'hFFB12E23);
            if (i == 9)  chk("big_w9", seq_instr_o, 32'hFD212C23);
            if (i == 10) chk("big_w10", seq_instr_o, 32'hFC912A23);
            if (i == 12) chk("big_w12", seq_instr_o, 32'hFC112623);
            if (i == 13) chk("big_w13", seq_instr_o, 32'hF9010113);
            chk($sformatf("big_last%0d", i), 32'(seq_last_o), 32'(i == 13));
            @(posedge clk); #1;
        end
        chk("big_done_first", 32'(seq_first_o), 32'd1);
        chk("big_done_active", 32'(seq_active_o), 32'd0);
        instr_valid_i = 1'b0;

        // cm.popretz {ra},16 with a two-cycle stall at step 1
        instr_i = 32'h0000BC42; instr_valid_i = 1'b1; seq_ready_i = 1'b1;
        @(negedge clk);
        chk("prz_w0", seq_instr_o, 32'h00C12083);
        @(posedge clk); #1;
        seq_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("prz_stall_w%0d", i), seq_instr_o, 32'h00000513);
            chk($sformatf("prz_stall_first%0d", i), 32'(seq_first_o), 32'd0);
            chk($sformatf("prz_stall_rdy%0d", i), 32'(instr_ready_o), 32'd0);
            chk($sformatf("prz_stall_act%0d", i), 32'(seq_active_o), 32'd1);
            @(posedge clk); #1;
        end
        seq_ready_i = 1'b1;
        exp_w[0] = 32'h00000513; exp_w[1] = 32'h01010113; exp_w[2] = 32'h00008067;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("prz_w%0d", i + 1), seq_instr_o, exp_w[i]);
            chk($sformatf("prz_last%0d", i + 1), 32'(seq_last_o), 32'(i == 2));
            @(posedge clk); #1;
        end
        instr_valid_i = 1'b0;

        // Kill on the last step of a push: kill wins, parcel re-presented from step 0
        instr_i = 32'h0000B852; instr_valid_i = 1'b1; seq_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        kill_i = 1'b1;
        @(negedge clk);
        chk("kill_valid", 32'(seq_valid_o), 32'd0);
        chk("kill_rdy", 32'(instr_ready_o), 32'd0);
        @(posedge clk); #1;
        kill_i = 1'b0;
        chk("kill_first", 32'(seq_first_o), 32'd1);
        chk("kill_active", 32'(seq_active_o), 32'd0);
        exp_w[0] = 32'hFE812E23; exp_w[1] = 32'hFE112C23; exp_w[2] = 32'hFF010113;
        run_seq("kill_re", 16'hB852, 3);

        // Asynchronous reset mid-sequence
        instr_i = 32'h0000B852; instr_valid_i = 1'b1; seq_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("arst_pre_active", 32'(seq_active_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_active", 32'(seq_active_o), 32'd0);
        chk("arst_first", 32'(seq_first_o), 32'd1);
        instr_valid_i = 1'b0;
        #1;
        chk("arst_valid", 32'(seq_valid_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_seq("post_rst", 16'hB852, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
